beam_trigger: RTL and testbench

- Per-string front end of the photonic harp; sits directly upstream of the per-string note countdown timer.
- Synchronises and debounces the raw photosensor beam signal and detects a pluck (beam break).
- Drives the timer's countdown, load and max_count inputs, and consumes its fin/half outputs to sequence one note per pluck.
- Publishes note_on and decay for the audio/voice stage.

---
 rtl/slike_pkg.sv | 21 ++
 rtl/beam_trigger_if.sv | 25 ++
 rtl/beam_debounce.sv | 56 +++++
 rtl/beam_trigger.sv | 100 ++++++++++
 tb/tb_beam_trigger.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/slike_pkg.sv
// Shared constants, state encoding and types for the photonic-harp string front end.
package slike_pkg;

  localparam int unsigned CNT_W               = 26;
  localparam int unsigned CLK_HZ              = 50_000_000;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = CLK_HZ / 100;  // 10 ms
  localparam int unsigned NOTE_LEN_DEF        = CLK_HZ;        // 1 s

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_PLAY = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StLoad = ST_LOAD,
    StPlay = ST_PLAY,
    StHold = ST_HOLD
  } state_e;

endpackage

// File: rtl/beam_trigger_if.sv
// Signals between a string's beam trigger, its photosensor and its note countdown timer.
interface beam_trigger_if;

  logic                         beam_in;
  logic                         fin;
  logic                         half;
  logic                         countdown;
  logic                         load;
  logic [slike_pkg::CNT_W-1:0]  max_count;
  logic                         note_on;
  logic                         decay;

  // Trigger side.
  modport master (
    input  beam_in, fin, half,
    output countdown, load, max_count, note_on, decay
  );

  // Sensor / timer / voice side.
  modport slave (
    output beam_in, fin, half,
    input  countdown, load, max_count, note_on, decay
  );

endinterface

// File: rtl/beam_debounce.sv
// Two-flop synchroniser and saturating debouncer for the raw beam level; flags each
// accepted beam break with a one-cycle pulse.
module beam_debounce
  import slike_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic beam_i,
  output logic beam_db_o,
  output logic brk_pulse_o
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             db_q, db_d;
  logic             brk_q, brk_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    brk_d = 1'b0;
    if (sync2_q != db_q) begin
      // >= keeps the counter from ever wrapping.
      if (cnt_q >= CntLast) begin
        db_d  = sync2_q;
        brk_d = db_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      db_q    <= 1'b1;
      brk_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= beam_i;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      brk_q   <= brk_d;
      cnt_q   <= cnt_d;
    end
  end

  assign beam_db_o   = db_q;
  assign brk_pulse_o = brk_q;

endmodule

// File: rtl/beam_trigger.sv
// Per-string pluck detector and note sequencer driving the note countdown timer.
// Define BEAM_TRIGGER_RETRIGGER_EN to let a fresh pluck restart a sounding note.
module beam_trigger
  import slike_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned NOTE_LEN        = NOTE_LEN_DEF
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  beam_trigger_if.master bus
);

`ifdef BEAM_TRIGGER_RETRIGGER_EN
  localparam bit Retrigger = 1'b1;
`else
  localparam bit Retrigger = 1'b0;
`endif

  logic   beam_db;
  logic   brk_pulse;
  state_e state_q;
  logic   countdown_q, load_q, note_on_q, decay_q;

  beam_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk_i      (CLOCK_50),
    .rst_ni     (reset),
    .beam_i     (bus.beam_in),
    .beam_db_o  (beam_db),
    .brk_pulse_o(brk_pulse)
  );

  // Outputs are registered alongside the state so each reflects the state being entered.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      countdown_q <= 1'b0;
      load_q      <= 1'b0;
      note_on_q   <= 1'b0;
      decay_q     <= 1'b0;
    end else begin
      load_q <= 1'b0;
      case (state_q)
        StIdle: begin
          countdown_q <= 1'b0;
          note_on_q   <= 1'b0;
          decay_q     <= 1'b0;
          if (brk_pulse) begin
            state_q     <= StLoad;
            load_q      <= 1'b1;
            countdown_q <= 1'b1;
            note_on_q   <= 1'b1;
          end
        end
        StLoad: begin
          state_q     <= StPlay;
          countdown_q <= 1'b1;
          note_on_q   <= 1'b1;
          decay_q     <= 1'b0;
        end
        StPlay: begin
          if (bus.fin) begin
            state_q     <= StHold;
            countdown_q <= 1'b0;
            note_on_q   <= 1'b0;
            decay_q     <= 1'b0;
          end else if (Retrigger && brk_pulse) begin
            state_q <= StLoad;
            load_q  <= 1'b1;
            decay_q <= 1'b0;
          end else begin
            decay_q <= bus.half;
          end
        end
        StHold: begin
          countdown_q <= 1'b0;
          note_on_q   <= 1'b0;
          decay_q     <= 1'b0;
          // Only a restored beam re-arms the string.
          if (beam_db) state_q <= StIdle;
        end
        default: begin
          state_q     <= StIdle;
          countdown_q <= 1'b0;
          note_on_q   <= 1'b0;
          decay_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.countdown = countdown_q;
  assign bus.load      = load_q;
  assign bus.note_on   = note_on_q;
  assign bus.decay     = decay_q;
  assign bus.max_count = CNT_W'(NOTE_LEN);

endmodule

// File: tb/tb_beam_trigger.sv
// Self-checking bench for beam_trigger: directed scenarios plus randomized beam/timer
// activity checked cycle by cycle against a behavioural model.
module tb_beam_trigger;

  localparam int DB        = 8;
  localparam int NOTE_EXP  = 50_000_000;
`ifdef BEAM_TRIGGER_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  beam_trigger_if bus ();

  beam_trigger #(
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .CLOCK_50(clk),
    .reset   (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state.
  bit m_s1, m_s2, m_db, m_brk;
  int m_run;
  int m_phase;  // 0 silent, 1 loading, 2 sounding, 3 waiting for beam restore
  bit e_cd, e_load, e_on, e_dec;

  task automatic model_reset();
    m_s1 = 1'b1; m_s2 = 1'b1; m_db = 1'b1; m_brk = 1'b0; m_run = 0; m_phase = 0;
    e_cd = 1'b0; e_load = 1'b0; e_on = 1'b0; e_dec = 1'b0;
  endtask

  task automatic model_step();
    bit pluck, restored;
    pluck    = m_brk;
    restored = m_db;
    e_load   = 1'b0;
    case (m_phase)
      0: if (pluck) begin
        m_phase = 1; e_load = 1'b1; e_cd = 1'b1; e_on = 1'b1; e_dec = 1'b0;
      end
      1: begin m_phase = 2; e_dec = 1'b0; end
      2: begin
        if (bus.fin) begin
          m_phase = 3; e_cd = 1'b0; e_on = 1'b0; e_dec = 1'b0;
        end else if (RETRIG && pluck) begin
          m_phase = 1; e_load = 1'b1; e_dec = 1'b0;
        end else begin
          e_dec = bus.half;
        end
      end
      default: if (restored) m_phase = 0;
    endcase
    // Level accepted after DB consecutive disagreeing cycles of the synchronised beam.
    m_brk = 1'b0;
    if (m_s2 != m_db) begin
      m_run++;
      if (m_run == DB) begin
        m_brk = m_db;
        m_db  = m_s2;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    m_s2 = m_s1;
    m_s1 = bus.beam_in;
  endtask

  // Advance one clock; returns on the following falling edge, where outputs are sampled.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.beam_in = i[0];
      tick();
      if ({bus.countdown, bus.load, bus.note_on, bus.decay} !== 4'b0000) begin
        failures++;
        $display("FAIL reset_outputs: got %b expected 0000",
                 {bus.countdown, bus.load, bus.note_on, bus.decay});
      end
      checks++;
      if (bus.max_count !== 26'(NOTE_EXP)) begin
        failures++;
        $display("FAIL reset_max_count: got %0d expected %0d", bus.max_count, NOTE_EXP);
      end
      checks++;
    end
    bus.beam_in = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.load !== 1'b0 || bus.countdown !== 1'b0) begin
        failures++;
        $display("FAIL reset_release: got load=%b countdown=%b expected 0 0",
                 bus.load, bus.countdown);
      end
      checks++;
    end
  endtask

  task automatic test_glitch();
    bus.beam_in = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    bus.beam_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.load !== 1'b0 || bus.countdown !== 1'b0) begin
        failures++;
        $display("FAIL glitch cyc=%0d: got load=%b countdown=%b expected 0 0",
                 i, bus.load, bus.countdown);
      end
      checks++;
    end
  endtask

  // Breaks the beam and checks the load arrives exactly 11 cycles later.
  task automatic pluck(input string tag);
    bus.beam_in = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (bus.load !== (k == 11)) begin
        failures++;
        $display("FAIL %s_load_timing k=%0d: got %b expected %b", tag, k, bus.load, k == 11);
      end
      checks++;
      if (k == 11 && (bus.countdown !== 1'b1 || bus.note_on !== 1'b1)) begin
        failures++;
        $display("FAIL %s_note_start: got countdown=%b note_on=%b expected 1 1",
                 tag, bus.countdown, bus.note_on);
      end
      if (k == 11) checks++;
    end
  endtask

  task automatic test_pluck();
    pluck("pluck");
    bus.half = 1'b1;
    tick();
    if (bus.decay !== 1'b1 || bus.note_on !== 1'b1) begin
      failures++;
      $display("FAIL half_decay: got decay=%b note_on=%b expected 1 1", bus.decay, bus.note_on);
    end
    checks++;
    bus.half = 1'b0;
    bus.fin  = 1'b1;
    tick();
    bus.fin = 1'b0;
    if ({bus.countdown, bus.note_on, bus.decay} !== 3'b000) begin
      failures++;
      $display("FAIL fin_end: got %b expected 000", {bus.countdown, bus.note_on, bus.decay});
    end
    checks++;
  endtask

  task automatic test_hold();
    int loads;
    loads = 0;
    for (int i = 0; i < 100; i++) begin
      bus.half = i[0];
      bus.fin  = i[1];
      tick();
      loads += int'(bus.load);
    end
    bus.half = 1'b0;
    bus.fin  = 1'b0;
    if (loads != 0 || bus.countdown !== 1'b0) begin
      failures++;
      $display("FAIL hold_no_retrigger: got loads=%0d countdown=%b expected 0 0",
               loads, bus.countdown);
    end
    checks++;
    bus.beam_in = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    pluck("rearm");
    bus.fin = 1'b1;
    tick();
    bus.fin = 1'b0;
    bus.beam_in = 1'b1;
    for (int i = 0; i < 12; i++) tick();
  endtask

  task automatic test_repluck();
    int loads;
    bit dropped;
    pluck("repluck_first");
    loads   = 0;
    dropped = 1'b0;
    bus.beam_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      loads += int'(bus.load);
      if (bus.note_on !== 1'b1) dropped = 1'b1;
    end
    bus.beam_in = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      loads += int'(bus.load);
      if (bus.note_on !== 1'b1) dropped = 1'b1;
    end
    if (loads != (RETRIG ? 1 : 0)) begin
      failures++;
      $display("FAIL repluck_loads: got %0d expected %0d", loads, RETRIG ? 1 : 0);
    end
    checks++;
    if (dropped) begin
      failures++;
      $display("FAIL repluck_note_on: got a drop expected note_on held at 1");
    end
    checks++;
    bus.fin = 1'b1;
    tick();
    bus.fin = 1'b0;
    if (bus.note_on !== 1'b0) begin
      failures++;
      $display("FAIL repluck_fin: got note_on=%b expected 0", bus.note_on);
    end
    checks++;
    bus.beam_in = 1'b1;
    for (int i = 0; i < 12; i++) tick();
  endtask

  task automatic test_midreset();
    pluck("midreset");
    bus.beam_in = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    if (bus.note_on !== 1'b1 || bus.countdown !== 1'b1) begin
      failures++;
      $display("FAIL midreset_playing: got note_on=%b countdown=%b expected 1 1",
               bus.note_on, bus.countdown);
    end
    checks++;
    #2 rst_n = 1'b0;
    #1;
    if (bus.countdown !== 1'b0 || bus.note_on !== 1'b0) begin
      failures++;
      $display("FAIL midreset_async: got countdown=%b note_on=%b expected 0 0",
               bus.countdown, bus.note_on);
    end
    checks++;
    model_reset();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.load !== 1'b0 || bus.countdown !== 1'b0) begin
        failures++;
        $display("FAIL midreset_release cyc=%0d: got load=%b countdown=%b expected 0 0",
                 i, bus.load, bus.countdown);
      end
      checks++;
    end
  endtask

  task automatic test_random();
    int run_left;
    bit prev_load;
    run_left  = 0;
    prev_load = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (run_left == 0) begin
        bus.beam_in = ~bus.beam_in;
        run_left    = int'($urandom_range(1, 16));
      end
      run_left--;
      bus.fin  = ($urandom_range(0, 29) == 0);
      bus.half = 1'($urandom_range(0, 1));
      tick();
      if ({bus.countdown, bus.load, bus.note_on, bus.decay} !== {e_cd, e_load, e_on, e_dec}) begin
        failures++;
        $display("FAIL random cyc=%0d: got cd/load/on/decay=%b expected %b", i,
                 {bus.countdown, bus.load, bus.note_on, bus.decay},
                 {e_cd, e_load, e_on, e_dec});
      end
      checks++;
      if (prev_load && bus.load) begin
        failures++;
        $display("FAIL load_twice cyc=%0d: got load high 2 cycles expected 1", i);
      end
      checks++;
      prev_load = bus.load;
    end
    bus.fin  = 1'b0;
    bus.half = 1'b0;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    bus.beam_in = 1'b1;
    bus.fin     = 1'b0;
    bus.half    = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_glitch();
    test_pluck();
    test_hold();
    test_repluck();
    test_midreset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
